// File: rtl/oam_iterative_pp_accumulator_if.sv
// Operand/result handshake bundle for the iterative OAM partial-product accumulator.
// The master side drives operands and Out_Ready; the slave side is the accumulator.
interface oam_iterative_pp_accumulator_if #(
  parameter int MANTISSA_WIDTH = 23,
  parameter int LEVEL_WIDTH    = 4
);
  localparam int ACC_WIDTH = 2 * MANTISSA_WIDTH + 2;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; once raised, Out_Valid and Result hold until that transfer.
  logic                      In_Valid;
  logic                      In_Ready;
  logic [MANTISSA_WIDTH-1:0] Mantissa_X;
  logic [MANTISSA_WIDTH-1:0] Mantissa_Y;
  logic [LEVEL_WIDTH-1:0]    Level;
  logic                      Out_Valid;
  logic                      Out_Ready;
  logic [ACC_WIDTH-1:0]      Result;
  logic [LEVEL_WIDTH-1:0]    Level_Used;
  logic                      Busy;

  modport master (
    output In_Valid, Mantissa_X, Mantissa_Y, Level, Out_Ready,
    input  In_Ready, Out_Valid, Result, Level_Used, Busy
  );

  modport slave (
    input  In_Valid, Mantissa_X, Mantissa_Y, Level, Out_Ready,
    output In_Ready, Out_Valid, Result, Level_Used, Busy
  );
endinterface

// File: rtl/oam_iterative_pp_accumulator.sv
// Iterative OAM approximate mantissa multiplier: one XNOR-headed partial-product
// pair per clock, accumulated at its arithmetic weight for a selectable level count.
module oam_iterative_pp_accumulator #(
  parameter int MANTISSA_WIDTH = 23,
  parameter int MAX_LEVEL      = 9,
  parameter int LEVEL_WIDTH    = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  oam_iterative_pp_accumulator_if.slave bus,
  output logic [1:0]                  dbg_state
);
  localparam int W         = MANTISSA_WIDTH;
  localparam int ACC_WIDTH = 2 * W + 2;
  localparam int POS_WIDTH = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [W-1:0]           x_q;
  logic [W-1:0]           y_q;
  logic [LEVEL_WIDTH-1:0] level_q;
  logic [LEVEL_WIDTH-1:0] j_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;

  logic [LEVEL_WIDTH-1:0] level_clamped;
  logic [POS_WIDTH-1:0]   pos;
  logic                   xj;
  logic                   yj;
  logic [W-1:0]           tail_mask;
  logic [W-1:0]           ppx;
  logic [W-1:0]           ppy;
  logic [ACC_WIDTH-1:0]   term;

  always_comb begin
    level_clamped = (bus.Level > LEVEL_WIDTH'(MAX_LEVEL)) ? LEVEL_WIDTH'(MAX_LEVEL) : bus.Level;
  end

  // Level j lives at vector index W-j; the tail is everything below it, and the
  // pair sum lands at weight 2^(W-j) in the accumulator.
  always_comb begin
    pos       = POS_WIDTH'(W) - POS_WIDTH'(j_q);
    xj        = x_q[pos];
    yj        = y_q[pos];
    tail_mask = ~({W{1'b1}} << pos);
    ppx       = ({{(W-1){1'b0}}, ~(xj ^ yj)} << pos) | ((xj ? y_q : ~y_q) & tail_mask);
    ppy       = (yj ? x_q : ~x_q) & tail_mask;
    term      = (ACC_WIDTH'(ppx) + ACC_WIDTH'(ppy)) << pos;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      level_q     <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.In_Valid && in_ready_q) begin
            x_q        <= bus.Mantissa_X;
            y_q        <= bus.Mantissa_Y;
            level_q    <= level_clamped;
            acc_q      <= '0;
            j_q        <= LEVEL_WIDTH'(1);
            in_ready_q <= 1'b0;
            if (level_clamped == '0) begin
              state       <= S_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state  <= S_RUN;
              busy_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_q + term;
          j_q   <= j_q + LEVEL_WIDTH'(1);
          if (j_q == level_q) begin
            state       <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          // Return to IDLE only; the next operand is taken on a later edge.
          if (bus.Out_Ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.In_Ready   = in_ready_q;
  assign bus.Out_Valid  = out_valid_q;
  assign bus.Busy       = busy_q;
  assign bus.Result     = acc_q;
  assign bus.Level_Used = level_q;
  assign dbg_state      = state;
endmodule

// File: tb/tb_oam_iterative_pp_accumulator.sv
// Bench for the iterative OAM accumulator: directed W=4 vectors with hand-computed
// results plus a W=23 random run against a bit-level reference sum.
module tb_oam_iterative_pp_accumulator;
  logic clk;
  logic rst_s;
  logic rst_b;
  logic [1:0] dbg_s;
  logic [1:0] dbg_b;

  int tests_run;
  int tests_failed;
  logic [47:0] exp_q[$];

  oam_iterative_pp_accumulator_if #(.MANTISSA_WIDTH(4),  .LEVEL_WIDTH(4)) bus_s ();
  oam_iterative_pp_accumulator_if #(.MANTISSA_WIDTH(23), .LEVEL_WIDTH(4)) bus_b ();

  oam_iterative_pp_accumulator #(.MANTISSA_WIDTH(4), .MAX_LEVEL(3), .LEVEL_WIDTH(4)) u_small (
    .Clk       (clk),
    .Rst       (rst_s),
    .bus       (bus_s),
    .dbg_state (dbg_s)
  );

  oam_iterative_pp_accumulator #(.MANTISSA_WIDTH(23), .MAX_LEVEL(9), .LEVEL_WIDTH(4)) u_big (
    .Clk       (clk),
    .Rst       (rst_b),
    .bus       (bus_b),
    .dbg_state (dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  // Reference: build each pair bit by bit from MSB-first numbering.
  function automatic longint ref_pp(input int w, input longint x, input longint y, input int l);
    longint acc;
    longint ppx;
    longint ppy;
    logic xj;
    logic yj;
    acc = 0;
    for (int j = 1; j <= l; j++) begin
      xj  = x[w-j];
      yj  = y[w-j];
      ppx = (xj == yj) ? (longint'(1) << (w - j)) : 0;
      ppy = 0;
      for (int k = j + 1; k <= w; k++) begin
        if (xj ? y[w-k] : !y[w-k]) ppx = ppx + (longint'(1) << (w - k));
        if (yj ? x[w-k] : !x[w-k]) ppy = ppy + (longint'(1) << (w - k));
      end
      acc = acc + ((ppx + ppy) << (w - j));
    end
    return acc;
  endfunction

  // driver: one full transaction on the W=4 instance, Out_Ready held high
  task automatic op_small(input string tag, input logic [3:0] x, input logic [3:0] y,
                          input logic [3:0] lvl, input int exp_res, input int exp_lu);
    int cnt;
    cnt = 0;
    while (!bus_s.In_Ready && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    bus_s.Mantissa_X = x;
    bus_s.Mantissa_Y = y;
    bus_s.Level      = lvl;
    bus_s.In_Valid   = 1'b1;
    @(posedge clk); #1;
    bus_s.In_Valid = 1'b0;
    cnt = 0;
    while (!bus_s.Out_Valid && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    check({tag, "_lat"}, cnt, exp_lu);
    check({tag, "_res"}, bus_s.Result, exp_res);
    check({tag, "_lu"}, bus_s.Level_Used, exp_lu);
    @(posedge clk); #1;
    check({tag, "_idle"}, bus_s.In_Ready, 1);
    check({tag, "_ovclr"}, bus_s.Out_Valid, 0);
  endtask

  initial begin
    int cnt;
    int held_bad;
    int seen;
    logic [22:0] rx;
    logic [22:0] ry;
    logic [3:0]  rl;
    int leff;

    tests_run    = 0;
    tests_failed = 0;
    rst_s = 1'b1;
    rst_b = 1'b1;
    bus_s.In_Valid = 1'b0; bus_s.Mantissa_X = '0; bus_s.Mantissa_Y = '0;
    bus_s.Level = '0; bus_s.Out_Ready = 1'b1;
    bus_b.In_Valid = 1'b0; bus_b.Mantissa_X = '0; bus_b.Mantissa_Y = '0;
    bus_b.Level = '0; bus_b.Out_Ready = 1'b1;

    #12;
    check("rst_in_ready",  bus_s.In_Ready, 1);
    check("rst_out_valid", bus_s.Out_Valid, 0);
    check("rst_busy",      bus_s.Busy, 0);
    check("rst_result",    bus_s.Result, 0);
    check("rst_level",     bus_s.Level_Used, 0);
    rst_s = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1;

    // level sweep, zero level, clamp
    op_small("l1", 4'b1010, 4'b1100, 4'd1, 112, 1);
    op_small("l2", 4'b1010, 4'b1100, 4'd2, 132, 2);
    op_small("l3", 4'b1010, 4'b1100, 4'd3, 134, 3);
    op_small("l0", 4'b1111, 4'b0101, 4'd0, 0, 0);
    op_small("l5", 4'b1010, 4'b1100, 4'd5, 134, 3);

    // back-pressure with a second operation waiting
    bus_s.Out_Ready  = 1'b0;
    bus_s.Mantissa_X = 4'b1010;
    bus_s.Mantissa_Y = 4'b1100;
    bus_s.Level      = 4'd2;
    bus_s.In_Valid   = 1'b1;
    @(posedge clk); #1;
    bus_s.Mantissa_X = 4'b0110;
    bus_s.Mantissa_Y = 4'b0011;
    bus_s.Level      = 4'd1;
    check("bp_busy", bus_s.Busy, 1);
    cnt = 0;
    while (!bus_s.Out_Valid && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    check("bp_lat", cnt, 2);
    held_bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!bus_s.Out_Valid || bus_s.Result !== 10'd132 || bus_s.In_Ready) held_bad++;
    end
    check("bp_hold", held_bad, 0);
    check("bp_res", bus_s.Result, 132);
    bus_s.Out_Ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ov", bus_s.Out_Valid, 0);
    check("bp_release_rdy", bus_s.In_Ready, 1);
    @(posedge clk); #1;
    bus_s.In_Valid = 1'b0;
    check("bp_second_acc", bus_s.In_Ready, 0);
    @(posedge clk); #1;
    check("bp_second_ov", bus_s.Out_Valid, 1);
    check("bp_second_res", bus_s.Result, 104);
    @(posedge clk); #1;

    // asynchronous reset during RUN at j=2
    bus_s.Mantissa_X = 4'b1010;
    bus_s.Mantissa_Y = 4'b1100;
    bus_s.Level      = 4'd3;
    bus_s.In_Valid   = 1'b1;
    @(posedge clk); #1;
    bus_s.In_Valid = 1'b0;
    @(posedge clk); #1;
    check("mr_busy_pre", bus_s.Busy, 1);
    check("mr_acc_pre", bus_s.Result, 112);
    #2 rst_s = 1'b1;
    #1;
    check("mr_in_ready",  bus_s.In_Ready, 1);
    check("mr_out_valid", bus_s.Out_Valid, 0);
    check("mr_busy",      bus_s.Busy, 0);
    check("mr_result",    bus_s.Result, 0);
    check("mr_level",     bus_s.Level_Used, 0);
    #2 rst_s = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus_s.Out_Valid) seen++;
    end
    check("mr_no_ov", seen, 0);
    check("mr_ready_after", bus_s.In_Ready, 1);

    // default-parameter random run; operands scrambled while RUN is in progress
    for (int n = 0; n < 1000; n++) begin
      rx   = 23'($urandom);
      ry   = 23'($urandom);
      rl   = 4'($urandom_range(0, 15));
      leff = (rl > 4'd9) ? 9 : int'(rl);
      exp_q.push_back(48'(ref_pp(23, longint'(rx), longint'(ry), leff)));
      cnt = 0;
      while (!bus_b.In_Ready && cnt < 40) begin
        @(posedge clk); #1; cnt++;
      end
      bus_b.Mantissa_X = rx;
      bus_b.Mantissa_Y = ry;
      bus_b.Level      = rl;
      bus_b.In_Valid   = 1'b1;
      @(posedge clk); #1;
      bus_b.In_Valid = 1'b0;
      cnt = 0;
      while (!bus_b.Out_Valid && cnt < 40) begin
        bus_b.Mantissa_X = 23'($urandom);
        bus_b.Mantissa_Y = 23'($urandom);
        bus_b.Level      = 4'($urandom);
        @(posedge clk); #1; cnt++;
      end
      check("rnd_lat", cnt, leff);
      check("rnd_res", bus_b.Result, exp_q.pop_front());
      check("rnd_lu", bus_b.Level_Used, leff);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/oam_iterative_pp_accumulator.md
# oam_iterative_pp_accumulator

- Sequential, runtime-configurable successor to the combinational OAM partial-product generator.
- Accepts one mantissa pair per transaction over a valid/ready handshake and generates the level-j partial-product pair (XNOR head bit plus conditionally inverted tail), one level per clock.
- Accumulates the pairs, at their arithmetic weights, into a full-width approximate mantissa product.
- Sits between mantissa unpacking and exponent/normalisation in the approximate multiplier. Trades accuracy for latency per operation through the `Level` input.

## Interface

Parameters:
- `MANTISSA_WIDTH`, default 23: mantissa width W, without the hidden bit.
- `MAX_LEVEL`, default 9: maximum number of levels; requires 1 ≤ MAX_LEVEL ≤ W−1.
- `LEVEL_WIDTH`, default 4: width of `Level`; must hold MAX_LEVEL.
- `ACC_WIDTH`: localparam, 2·W+2. Accumulator and result width.

Ports:
- `Clk`, input, 1: clock. One clock domain; all logic on the rising edge.
- `Rst`, input, 1: reset, asynchronous and active-high.
- `In_Valid`, input, 1: operands and level are valid.
- `In_Ready`, output, 1: block can accept a new operation.
- `Mantissa_X`, input, W: operand X; bit W−1 is mantissa bit 1 (MSB).
- `Mantissa_Y`, input, W: operand Y; same convention.
- `Level`, input, LEVEL_WIDTH: number of levels L to accumulate.
- `Out_Valid`, output, 1: `Result` is valid.
- `Out_Ready`, input, 1: downstream accepts `Result`.
- `Result`, output, ACC_WIDTH: accumulated approximate product, in integer units of 2^−2W.
- `Level_Used`, output, LEVEL_WIDTH: effective L after clamping.
- `Busy`, output, 1: high in the RUN state.

## Operation

- **Bit numbering.** Mantissa bits are numbered MSB-first, 1..W; bit k is vector index W−k.
- **Level j pair,** for 1 ≤ j ≤ L:
  - PPX_j = {x_j XNOR y_j, x_j ? y[j+1..W] : ~y[j+1..W]}, width W−j+1.
  - PPY_j = {1'b0, y_j ? x[j+1..W] : ~x[j+1..W]}, width W−j+1.
- **Level contribution.** T_j = (PPX_j + PPY_j) << (W−j), zero-extended to ACC_WIDTH.
  - Result = Σ T_j for j = 1..L.
  - ACC_WIDTH cannot overflow; no saturation logic.
- **Clamping.** Effective L = min(`Level`, MAX_LEVEL), latched at accept. `Level_Used` reports it.
- **Operand capture.** X and Y are registered at accept. Input changes afterwards have no effect.
- **State machine.** States are IDLE, RUN and DONE.
  - IDLE: `In_Ready` = 1. On `In_Valid` & `In_Ready`:
    - Latch operands and L, clear the accumulator, set j = 1.
    - Go to RUN if L ≥ 1.
    - Go to DONE if L = 0; `Result` = 0.
  - RUN: each edge adds T_j and increments j. On the edge where j == L, go to DONE.
  - DONE: `Out_Valid` = 1; `Result` and `Level_Used` are held stable. On `Out_Valid` & `Out_Ready`, go to IDLE.
- **Back-pressure.** `In_Ready` is low in RUN and DONE, so nothing is accepted while a result is pending. The DONE-to-IDLE edge does not accept new input in the same cycle.
- **Reset.**
  - `Rst` asserted at any time, including mid-RUN or DONE, immediately forces IDLE.
  - The in-flight operation is discarded with no partial result emitted.
  - Output values under reset:
    - `In_Ready` = 1.
    - `Out_Valid` = 0.
    - `Busy` = 0.
    - `Result` = 0.
    - `Level_Used` = 0.

## Timing

- **Accept edge.** Edge A is the rising edge where `In_Valid` & `In_Ready` are sampled high.
- **Latency to `Out_Valid`.**
  - L = 0: `Out_Valid` rises at edge A.
  - L ≥ 1: `Out_Valid` rises at edge A+L.
- **Throughput.** One operation per L+2 cycles at most, with `Out_Ready` held high.
- **Result stability.** `Result` may change only on edges in RUN and on the accept edge; it is stable throughout DONE.
- **Registered outputs.** `In_Ready`, `Out_Valid` and `Busy` are decoded from registered state only; there is no combinational path from inputs to outputs.
- **Held valid.** If `Out_Ready` is low, `Out_Valid` stays high indefinitely with `Result` unchanged.

## Test plan

All scenarios use W=4, MAX_LEVEL=3 (ACC_WIDTH=10) unless stated.

- **Level sweep.** X=4'b1010, Y=4'b1100 at L=1, 2, 3 → Result = 112, 132, 134 respectively. `Out_Valid` rises at A+1, A+2, A+3.
- **Zero level and clamp.**
  - L=0, any operands → Result=0, `Out_Valid` at edge A, `Level_Used`=0.
  - L=5, X=1010, Y=1100 → Result=134, `Level_Used`=3.
- **Back-pressure.** L=2 with `Out_Ready` low for 10 cycles → `Out_Valid` and Result=132 are held; `In_Ready` stays 0.
  - Then `Out_Ready`=1 → IDLE next edge.
  - A second operation presented meanwhile is not accepted until IDLE.
- **Reset mid-RUN.** Assert `Rst` asynchronously during RUN at j=2 → outputs take reset values without waiting for a clock edge; no `Out_Valid` pulse afterwards.
- **Default-parameter random check.** W=23, MAX_LEVEL=9, 1000 random X/Y/Level values compared against the reference Σ T_j model. Checks:
  - exact Result match;
  - cycle-exact `Out_Valid` timing;
  - operand changes during RUN do not affect Result.
